// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel buffer types, widths and pack/parity helper
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        WRITE = 2'd2
    } pix_state_t;

    localparam int PIX_WORD_W = 32;
    localparam int PIX_PAR_W  = 4;

    typedef struct packed {
        logic [PIX_WORD_W-1:0] word;
        logic [PIX_PAR_W-1:0]  par;
    } pix_packed_t;

    // Even parity per byte; the top byte is always zero so par[3] is always 0.
    function automatic pix_packed_t pack_pixel(input logic [7:0] red,
                                               input logic [7:0] green,
                                               input logic [7:0] blue);
        pix_packed_t p;
        p.word = {8'h00, red, green, blue};
        for (int i = 0; i < PIX_PAR_W; i++) begin
            p.par[i] = ^p.word[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// rtl/pixel_writer_if.sv - valid/ready RGB pixel stream with first-of-frame marker
interface pixel_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sof;
    logic [DATA_WIDTH-1:0] red_data;
    logic [DATA_WIDTH-1:0] green_data;
    logic [DATA_WIDTH-1:0] blue_data;

    modport master (
        output pix_valid, pix_sof, red_data, green_data, blue_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_sof, red_data, green_data, blue_data,
        output pix_ready
    );
endinterface

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - registered RGB to {word, parity} packing stage with enable
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] red,
    input  logic [DATA_WIDTH-1:0] green,
    input  logic [DATA_WIDTH-1:0] blue,
    output logic [PIX_WORD_W-1:0] word,
    output logic [PIX_PAR_W-1:0]  par
);

    pix_packed_t packed_c;

    assign packed_c = pack_pixel(red, green, blue);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
            par  <= '0;
        end else if (en) begin
            word <= packed_c.word;
            par  <= packed_c.par;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - loads one frame of packed pixels into a 512x36 block RAM
module pixel_writer
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int FRAME_WORDS = 512
) (
    input  logic                  SYS_CLK,
    input  logic                  SYS_RST_N,
    input  logic                  start,
    pixel_writer_if.slave         pix,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [PIX_WORD_W-1:0] ram_di,
    output logic [PIX_PAR_W-1:0]  ram_dip,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    pix_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] count, count_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr, wr_done, wr_err;
    logic                  ready_q;
    logic                  accept;

    assign accept        = pix.pix_valid && ready_q;
    assign pix.pix_ready = ready_q;
    assign ram_en        = ram_we;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr        = 1'b0;
        wr_addr   = count;
        wr_done   = 1'b0;
        wr_err    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SYNC;
                    count_nxt = '0;
                end
            end
            SYNC: begin
                // Pixels before the first SOF belong to a partial frame and are dropped.
                if (accept && pix.pix_sof) begin
                    wr      = 1'b1;
                    wr_addr = '0;
                    if (LAST_ADDR == '0) begin
                        wr_done   = 1'b1;
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else begin
                        state_nxt = WRITE;
                        count_nxt = ADDR_WIDTH'(1);
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    wr = 1'b1;
                    if (pix.pix_sof && count != '0) begin
                        wr_err    = 1'b1;
                        wr_addr   = '0;
                        count_nxt = ADDR_WIDTH'(1);
                    end else if (count == LAST_ADDR) begin
                        wr_done   = 1'b1;
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state     <= IDLE;
            count     <= '0;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            ready_q   <= (state_nxt != IDLE);
            busy      <= (state_nxt != IDLE);
            ram_we    <= wr;
            done      <= wr_done;
            frame_err <= wr_err;
            if (wr) begin
                ram_addr <= wr_addr;
            end
        end
    end

    pixel_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .en    (wr),
        .red   (pix.red_data),
        .green (pix.green_data),
        .blue  (pix.blue_data),
        .word  (ram_di),
        .par   (ram_dip)
    );

endmodule
